// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for a 4-bit up/down counter: clears the counter, seeks to lo,
// then runs a programmed number of lo->hi->lo sweeps with a dwell at each turning point.
module updown_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] sweeps,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               pause,
    input  logic               abort,
    input  logic [WIDTH-1:0]   count,
    output logic               cnt_clr,
    output logic               cnt_en,
    output logic               cnt_up,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_idx
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_SEEK     = 3'd2;
    localparam logic [2:0] S_UP       = 3'd3;
    localparam logic [2:0] S_DWELL_HI = 3'd4;
    localparam logic [2:0] S_DOWN     = 3'd5;
    localparam logic [2:0] S_DWELL_LO = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]         state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [SWEEP_W-1:0] sweeps_q, sweeps_d, idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dcnt_q, dcnt_d;
    logic               err_q, err_d;

    logic               aborting;
    logic               frozen;
    logic [SWEEP_W-1:0] idx_inc;

    assign aborting = abort && (state_q != S_IDLE);
    assign frozen   = pause && (state_q != S_IDLE) && (state_q != S_DONE);
    assign idx_inc  = idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        sweeps_d = sweeps_q;
        dwell_d  = dwell_q;
        dcnt_d   = dcnt_q;
        idx_d    = idx_q;
        err_d    = 1'b0;
        if (aborting) begin
            state_d = S_IDLE;
        end else if (!frozen) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if ((lo < hi) && (sweeps != '0)) begin
                            lo_d     = lo;
                            hi_d     = hi;
                            sweeps_d = sweeps;
                            dwell_d  = dwell;
                            idx_d    = '0;
                            state_d  = S_CLEAR;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_CLEAR: state_d = S_SEEK;
                S_SEEK: begin
                    if (count == lo_q) state_d = S_UP;
                end
                S_UP: begin
                    if (count == hi_q) begin
                        dcnt_d  = dwell_q;
                        state_d = S_DWELL_HI;
                    end
                end
                S_DWELL_HI: begin
                    if (dcnt_q == '0) state_d = S_DOWN;
                    else              dcnt_d  = dcnt_q - 1'b1;
                end
                S_DOWN: begin
                    if (count == lo_q) begin
                        idx_d = idx_inc;
                        if (idx_inc == sweeps_q) begin
                            state_d = S_DONE;
                        end else begin
                            dcnt_d  = dwell_q;
                            state_d = S_DWELL_LO;
                        end
                    end
                end
                S_DWELL_LO: begin
                    if (dcnt_q == '0) state_d = S_UP;
                    else              dcnt_d  = dcnt_q - 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counter controls: abort and pause both suppress any counter movement in the same cycle.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        cnt_up  = 1'b0;
        case (state_q)
            S_CLEAR: cnt_clr = !aborting && !frozen;
            S_SEEK: begin
                cnt_up = (count != lo_q);
                cnt_en = !aborting && !frozen && (count != lo_q);
            end
            S_UP: begin
                cnt_up = (count != hi_q);
                cnt_en = !aborting && !frozen && (count != hi_q);
            end
            S_DOWN: cnt_en = !aborting && !frozen && (count != lo_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            sweeps_q <= '0;
            dwell_q  <= '0;
            dcnt_q   <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            sweeps_q <= sweeps_d;
            dwell_q  <= dwell_d;
            dcnt_q   <= dcnt_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign sweep_idx = idx_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl driving a behavioural 4-bit up/down counter;
// expected done/err events are queued at issue time and checked by an independent monitor.
module tb_updown_sweep_ctrl;

    localparam int W  = 4;
    localparam int SW = 8;
    localparam int DW = 4;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [W-1:0]  lo = '0, hi = '0, count;
    logic [SW-1:0] sweeps = '0;
    logic [DW-1:0] dwell = '0;
    logic          cnt_clr, cnt_en, cnt_up, busy, done, err;
    logic [SW-1:0] sweep_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        bit is_err;
        int cyc;
        int idx;
        int lo;
        int hi;
    } exp_t;
    exp_t exp_q[$];

    updown_sweep_ctrl #(.WIDTH(W), .SWEEP_W(SW), .DWELL_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .lo(lo), .hi(hi), .sweeps(sweeps),
        .dwell(dwell), .pause(pause), .abort(abort), .count(count),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_up(cnt_up), .busy(busy),
        .done(done), .err(err), .sweep_idx(sweep_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter being sequenced; its reset is the system reset ORed with cnt_clr.
    always @(posedge clk) begin
        if (reset || cnt_clr) count <= '0;
        else if (cnt_en)      count <= cnt_up ? count + 1'b1 : count - 1'b1;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc + 1);
        end
    endtask

    function automatic int done_off(input int l, input int h, input int s, input int d);
        return 3 + l + s * (2 * (h - l) + d + 3) + (s - 1) * (d + 1);
    endfunction

    // Monitor: cycle j ends at posedge j, so at a negedge the current cycle is cyc+1.
    int max_cnt = 0;
    bit chk_idle_next = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_idle_next) begin
            check("busy_after_done", int'(busy), 0);
            chk_idle_next = 1'b0;
        end
        if (cnt_clr) max_cnt = 0;
        else if (busy && int'(count) > max_cnt) max_cnt = int'(count);
        if (done || err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, err, done}, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err) begin
                    check("err_seen", int'(err), 1);
                    check("err_cycle", cyc + 1, e.cyc);
                    check("busy_on_reject", int'(busy), 0);
                end else begin
                    check("done_seen", int'(done), 1);
                    check("done_cycle", cyc + 1, e.cyc);
                    check("done_sweep_idx", int'(sweep_idx), e.idx);
                    check("done_count", int'(count), e.lo);
                    check("sweep_peak", max_cnt, e.hi);
                    chk_idle_next = 1'b1;
                end
            end
        end
    end

    task automatic issue(input int l, input int h, input int s, input int d,
                         input bit push, input int extra);
        exp_t e;
        int k;
        @(negedge clk);
        lo = W'(l); hi = W'(h); sweeps = SW'(s); dwell = DW'(d);
        start = 1'b1;
        k = cyc + 1;
        if (push) begin
            e.lo = l; e.hi = h; e.idx = s;
            if (l < h && s != 0) begin
                e.is_err = 1'b0;
                e.cyc = k + done_off(l, h, s, d) + extra;
            end else begin
                e.is_err = 1'b1;
                e.cyc = k + 1;
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy || exp_q.size() != 0) begin
            @(negedge clk); #1;
            n++;
            if (n > budget) begin
                check("wait_idle_timeout", n, budget);
                exp_q.delete();
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Waits at negedges (plus settle) until the given condition holds.
    task automatic wait_for(input string name, input int sel, input int val, input int budget);
        int n = 0;
        bit hit;
        forever begin
            @(negedge clk); #1;
            case (sel)
                0: hit = busy && !cnt_en && int'(count) == val;  // holding at top
                1: hit = busy && cnt_en && cnt_up && int'(count) == val;
                default: hit = busy && cnt_en && !cnt_up && int'(count) == val;
            endcase
            if (hit) return;
            n++;
            if (n > budget) begin
                check(name, n, budget);
                return;
            end
        end
    endtask

    initial begin
        int frz;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_cnt_clr", int'(cnt_clr), 0);
        check("rst_cnt_en", int'(cnt_en), 0);
        check("rst_cnt_up", int'(cnt_up), 0);
        check("rst_sweep_idx", int'(sweep_idx), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single sweep, multi-sweep with dwell, rejects, full range
        issue(2, 5, 1, 0, 1'b1, 0);  wait_idle(100);
        issue(0, 3, 2, 2, 1'b1, 0);  wait_idle(100);
        issue(5, 5, 1, 0, 1'b1, 0);  wait_idle(10);
        issue(1, 4, 0, 0, 1'b1, 0);  wait_idle(10);
        issue(0, 15, 1, 0, 1'b1, 0); wait_idle(100);

        // Start while busy must be ignored
        issue(1, 4, 1, 1, 1'b1, 0);
        repeat (4) @(negedge clk);
        lo = 4'd0; hi = 4'd2; sweeps = 8'd3; dwell = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);

        // Pause 4 cycles during UP
        issue(2, 5, 1, 0, 1'b1, 4);
        wait_for("pause_reach_up", 1, 3, 30);
        pause = 1'b1;
        frz = int'(count);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("pause_cnt_en", int'(cnt_en), 0);
            check("pause_count", int'(count), frz);
            @(negedge clk);
        end
        pause = 1'b0;
        wait_idle(100);

        // Abort during DOWN at count 4
        issue(2, 5, 1, 0, 1'b0, 0);
        wait_for("abort_reach_down", 2, 4, 30);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_cnt_en", int'(cnt_en), 0);
        check("abort_sweep_idx", int'(sweep_idx), 0);
        repeat (3) @(negedge clk);
        check("abort_count_held", int'(count), 4);

        // Reset during DWELL_HI
        issue(1, 3, 2, 2, 1'b0, 0);
        wait_for("reset_reach_top", 0, 3, 30);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        check("mrst_cnt_en", int'(cnt_en), 0);
        check("mrst_cnt_clr", int'(cnt_clr), 0);
        check("mrst_sweep_idx", int'(sweep_idx), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles, required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
